alu_rs_scheduler: RTL and testbench
===================================

ALU_RS_SCHEDULER -- requirements
Module: alu_rs_scheduler

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8: number of station entries, a power of two.
REQ-002 SHALL have parameter ID_WIDTH, default 4: ROB tag width.
REQ-003 SHALL have parameter VAL_WIDTH / OP_WIDTH / ADDR_WIDTH, defaults 32 / 7 / 32: operand, opcode-class and PC widths.
REQ-004 SHALL have ports clk in 1, the single clock; rst_in in 1, reset (asynchronous, active-high); rdy_in in 1, global stall when low.
REQ-005 SHALL have ports clear in 1, misprediction flush; rs_full out 1, no free entry.
REQ-006 SHALL have ports inst_valid in 1, inst_type in OP_WIDTH, inst_entry in ID_WIDTH and inst_pc in ADDR_WIDTH: the dispatch request, its opcode class, its ROB tag and its PC.
REQ-007 SHALL have ports inst_val1 / inst_val2 in VAL_WIDTH, inst_q1_busy / inst_q2_busy in 1 and inst_q1 / inst_q2 in ID_WIDTH: operand values, pending flags and producer tags.
REQ-008 SHALL have ports alu_cdb_valid in 1, alu_cdb_entry in ID_WIDTH, alu_cdb_val in VAL_WIDTH: ALU result broadcast.
REQ-009 SHALL have ports lsb_cdb_valid in 1, lsb_cdb_entry in ID_WIDTH, lsb_cdb_val in VAL_WIDTH: load/store result broadcast.
REQ-010 SHALL have ports execute out 1, type out OP_WIDTH, val1 / val2 out VAL_WIDTH, entry out ID_WIDTH and nowPC out ADDR_WIDTH: the registered issue to the ALU.

Function
REQ-011 SHALL keep per entry: busy, type, val1, val2, q1_busy, q1, q2_busy, q2, rob tag and pc.
REQ-012 SHALL write a dispatch on a clk edge when inst_valid=1, rdy_in=1, clear=0 and rs_full=0, into the lowest-index non-busy entry.
REQ-013 SHALL ignore and drop inst_valid while rs_full=1; the dispatcher is responsible for holding the request.
REQ-014 SHALL drive rs_full combinationally high when all RS_SIZE entries are busy.
REQ-015 SHALL, for each busy entry with qN_busy=1 and qN equal to a valid CDB tag, capture that CDB value into valN and clear qN_busy on the same edge.
REQ-016 SHALL, when both CDBs match the same operand, take the ALU CDB.
REQ-017 SHALL, when an incoming dispatch operand matches a same-cycle CDB tag, store the CDB value with qN_busy=0; no result is lost at insertion.
REQ-018 SHALL treat an entry as ready when busy=1, q1_busy=0 and q2_busy=0, using registered state.
REQ-019 SHALL select, each cycle, the lowest-index ready entry.
REQ-020 SHALL, on the next edge, register the selected entry's fields onto type/val1/val2/entry/nowPC, set execute=1 and clear that entry's busy.
REQ-021 SHALL issue with a latency of 1 cycle from ready to execute=1, at a throughput of 1 issue per cycle.
REQ-022 SHALL drive execute=0 on an edge where no entry is ready; the data outputs hold their last values.
REQ-023 SHALL allow dispatch and issue on the same edge; an entry freed by issue is not reusable until the following cycle.
REQ-024 SHALL, on clear=1 at an edge, clear all busy bits and set execute=0, with no issue; clear overrides dispatch, wakeup and issue.
REQ-025 SHALL, when rdy_in=0, freeze all state and outputs (execute holds its value), and drop CDB inputs and dispatch for that cycle.
REQ-026 SHALL NOT issue a freshly dispatched entry before the following edge, even if both operands are ready.

Reset
REQ-027 SHALL, while rst_in=1 (asynchronous, independent of clk and rdy_in), clear all busy bits and drive execute=0, with type/val1/val2/entry/nowPC=0.
REQ-028 SHALL, on reset mid-operation, discard all pending entries and in-flight issue; rs_full=0 immediately.

Configuration
REQ-029 SHALL, with ALU_RS_CDB_BYPASS_EN defined, also treat as ready an entry whose last pending operand matches a CDB this cycle; that entry issues on the same edge with the CDB value forwarded into val1/val2 (0-cycle wakeup).
REQ-030 SHALL, with ALU_RS_CDB_BYPASS_EN undefined, issue a woken entry no earlier than 1 cycle after its CDB capture (per REQ-018).

Verification
REQ-031 SHALL cover: reset, then dispatch addi type, val1=5, val2=7, tag 3, no deps -> next-cycle execute=1, entry=3, val1=5, val2=7; the following cycle execute=0.
REQ-032 SHALL cover: dispatch q1_busy=1, q1=2; alu_cdb_valid=1, entry 2, val 0x10 two cycles later -> val1=0x10 issues 2 cycles after CDB without bypass, 1 cycle after with bypass.
REQ-033 SHALL cover: fill 8 entries, all dependent on tag 9 -> rs_full=1 and a 9th dispatch is ignored; alu_cdb tag 9 -> 8 issues in index order 0..7 on consecutive cycles.
REQ-034 SHALL cover: same-cycle dispatch with q2=4 while lsb_cdb tag 4, val 0xAB -> entry stored with val2=0xAB and issues next cycle.
REQ-035 SHALL cover: 3 ready entries plus clear=1 -> execute=0 and rs_full=0 next cycle, with no later issue; and rst_in pulsed mid-issue -> execute=0 asynchronously.
REQ-036 SHALL cover: rdy_in=0 for 3 cycles with a ready entry -> no issue and no state change; issue occurs on the first edge with rdy_in=1.

Source files
------------

// File: rtl/alu_rs_scheduler_if.sv
// alu_rs_scheduler_if: dispatch, CDB and issue bus of the ALU reservation station.
// master drives rdy_in, clear, the inst_* dispatch request and both CDBs;
// slave (the station) drives rs_full and the registered issue
// (execute, issue_type, val1, val2, entry, nowPC).
interface alu_rs_scheduler_if #(
    parameter int ID_WIDTH   = 4,
    parameter int VAL_WIDTH  = 32,
    parameter int OP_WIDTH   = 7,
    parameter int ADDR_WIDTH = 32
);
    logic                  rdy_in, clear, rs_full;
    logic                  inst_valid;
    logic [OP_WIDTH-1:0]   inst_type;
    logic [ID_WIDTH-1:0]   inst_entry;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic [VAL_WIDTH-1:0]  inst_val1, inst_val2;
    logic                  inst_q1_busy, inst_q2_busy;
    logic [ID_WIDTH-1:0]   inst_q1, inst_q2;
    logic                  alu_cdb_valid, lsb_cdb_valid;
    logic [ID_WIDTH-1:0]   alu_cdb_entry, lsb_cdb_entry;
    logic [VAL_WIDTH-1:0]  alu_cdb_val, lsb_cdb_val;
    logic                  execute;
    logic [OP_WIDTH-1:0]   issue_type;
    logic [VAL_WIDTH-1:0]  val1, val2;
    logic [ID_WIDTH-1:0]   entry;
    logic [ADDR_WIDTH-1:0] nowPC;
    modport master (
        output rdy_in, clear, inst_valid, inst_type, inst_entry, inst_pc, inst_val1, inst_val2,
               inst_q1_busy, inst_q2_busy, inst_q1, inst_q2,
               alu_cdb_valid, alu_cdb_entry, alu_cdb_val, lsb_cdb_valid, lsb_cdb_entry, lsb_cdb_val,
        input  rs_full, execute, issue_type, val1, val2, entry, nowPC
    );
    modport slave (
        input  rdy_in, clear, inst_valid, inst_type, inst_entry, inst_pc, inst_val1, inst_val2,
               inst_q1_busy, inst_q2_busy, inst_q1, inst_q2,
               alu_cdb_valid, alu_cdb_entry, alu_cdb_val, lsb_cdb_valid, lsb_cdb_entry, lsb_cdb_val,
        output rs_full, execute, issue_type, val1, val2, entry, nowPC
    );
endinterface

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: ALU reservation station with CDB wakeup and lowest-index issue.
// Ports: clk; rst_in (async, active-high); bus (alu_rs_scheduler_if.slave) carrying
// stall/flush, dispatch request, ALU/LSB CDBs, rs_full and the registered issue.
// Define ALU_RS_CDB_BYPASS_EN to let an entry issue on the same edge its last operand arrives.
module alu_rs_scheduler #(
    parameter int RS_SIZE    = 8,
    parameter int ID_WIDTH   = 4,
    parameter int VAL_WIDTH  = 32,
    parameter int OP_WIDTH   = 7,
    parameter int ADDR_WIDTH = 32
) (
    input logic clk,
    input logic rst_in,
    alu_rs_scheduler_if.slave bus
);
    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]    busy, q1b, q2b, m1, m2, ready;
    logic [OP_WIDTH-1:0]   typ [RS_SIZE];
    logic [VAL_WIDTH-1:0]  v1 [RS_SIZE], v2 [RS_SIZE], w1 [RS_SIZE], w2 [RS_SIZE];
    logic [VAL_WIDTH:0]    s1 [RS_SIZE], s2 [RS_SIZE];
    logic [ID_WIDTH-1:0]   q1 [RS_SIZE], q2 [RS_SIZE], tag [RS_SIZE];
    logic [ADDR_WIDTH-1:0] pc [RS_SIZE];
    logic [IW-1:0]         free_idx, sel;
    logic                  any, d1b, d2b;
    logic [VAL_WIDTH:0]    ds1, ds2;
    logic [VAL_WIDTH-1:0]  d1, d2;

    // {hit, value} for a tag against both CDBs; the ALU CDB wins a double hit
    function automatic logic [VAL_WIDTH:0] snoop(input logic [ID_WIDTH-1:0] q);
        return (bus.alu_cdb_valid && q == bus.alu_cdb_entry) ? {1'b1, bus.alu_cdb_val}
             : (bus.lsb_cdb_valid && q == bus.lsb_cdb_entry) ? {1'b1, bus.lsb_cdb_val} : '0;
    endfunction

    assign bus.rs_full = &busy;

    always_comb begin
        m1 = '0;
        m2 = '0;
        ready = '0;
        free_idx = '0;
        sel = '0;
        any = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            s1[i] = snoop(q1[i]);
            s2[i] = snoop(q2[i]);
            m1[i] = busy[i] & q1b[i] & s1[i][VAL_WIDTH];
            m2[i] = busy[i] & q2b[i] & s2[i][VAL_WIDTH];
            w1[i] = m1[i] ? s1[i][VAL_WIDTH-1:0] : v1[i];
            w2[i] = m2[i] ? s2[i][VAL_WIDTH-1:0] : v2[i];
`ifdef ALU_RS_CDB_BYPASS_EN
            ready[i] = busy[i] & (~q1b[i] | m1[i]) & (~q2b[i] | m2[i]);
`else
            ready[i] = busy[i] & ~q1b[i] & ~q2b[i];
`endif
            // descending scan leaves the lowest index in free_idx/sel
            if (!busy[i]) free_idx = IW'(i);
            if (ready[i]) begin
                sel = IW'(i);
                any = 1'b1;
            end
        end
        ds1 = snoop(bus.inst_q1);
        ds2 = snoop(bus.inst_q2);
        d1b = bus.inst_q1_busy & ~ds1[VAL_WIDTH];
        d2b = bus.inst_q2_busy & ~ds2[VAL_WIDTH];
        d1 = (bus.inst_q1_busy && ds1[VAL_WIDTH]) ? ds1[VAL_WIDTH-1:0] : bus.inst_val1;
        d2 = (bus.inst_q2_busy && ds2[VAL_WIDTH]) ? ds2[VAL_WIDTH-1:0] : bus.inst_val2;
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            busy <= '0;
            q1b <= '0;
            q2b <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                typ[i] <= '0;
                v1[i] <= '0;
                v2[i] <= '0;
                q1[i] <= '0;
                q2[i] <= '0;
                tag[i] <= '0;
                pc[i] <= '0;
            end
            bus.execute <= 1'b0;
            bus.issue_type <= '0;
            bus.val1 <= '0;
            bus.val2 <= '0;
            bus.entry <= '0;
            bus.nowPC <= '0;
        end else if (bus.rdy_in) begin
            if (bus.clear) begin
                busy <= '0;
                bus.execute <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (m1[i]) begin
                        v1[i] <= w1[i];
                        q1b[i] <= 1'b0;
                    end
                    if (m2[i]) begin
                        v2[i] <= w2[i];
                        q2b[i] <= 1'b0;
                    end
                end
                bus.execute <= any;
                if (any) begin
                    bus.issue_type <= typ[sel];
                    bus.val1 <= w1[sel];
                    bus.val2 <= w2[sel];
                    bus.entry <= tag[sel];
                    bus.nowPC <= pc[sel];
                    busy[sel] <= 1'b0;
                end
                // free_idx comes from registered busy, so a slot freed by this issue waits a cycle
                if (bus.inst_valid && !bus.rs_full) begin
                    busy[free_idx] <= 1'b1;
                    typ[free_idx] <= bus.inst_type;
                    tag[free_idx] <= bus.inst_entry;
                    pc[free_idx] <= bus.inst_pc;
                    v1[free_idx] <= d1;
                    v2[free_idx] <= d2;
                    q1b[free_idx] <= d1b;
                    q2b[free_idx] <= d2b;
                    q1[free_idx] <= bus.inst_q1;
                    q2[free_idx] <= bus.inst_q2;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb_alu_rs_scheduler: directed vector table plus corner sequences for alu_rs_scheduler.
module tb_alu_rs_scheduler;
`ifdef ALU_RS_CDB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    typedef struct {
        int iv, ityp, itag, iv1, iv2, q1b, q1, q2b, q2;
        int av, ae, aval, lv, le, lval;
        int e_exe, e_tag, e_v1, e_v2, e_typ;
    } vec_t;

    logic clk = 1'b0;
    logic rst_in = 1'b1;
    int tests = 0;
    int fails = 0;
    vec_t vecs [15];

    alu_rs_scheduler_if bus ();
    alu_rs_scheduler #(.RS_SIZE(8)) dut (.clk(clk), .rst_in(rst_in), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] pc_of(input int t);
        return 32'h1000 + 32'(t) * 4;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inst_valid = 1'b0;
        bus.inst_q1_busy = 1'b0;
        bus.inst_q2_busy = 1'b0;
        bus.alu_cdb_valid = 1'b0;
        bus.lsb_cdb_valid = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic disp(input int t, input int a, input int b, input logic qb, input int q);
        idle();
        bus.inst_valid = 1'b1;
        bus.inst_type = 7'h13;
        bus.inst_entry = 4'(t);
        bus.inst_pc = pc_of(t);
        bus.inst_val1 = 32'(a);
        bus.inst_val2 = 32'(b);
        bus.inst_q1_busy = qb;
        bus.inst_q1 = 4'(q);
    endtask

    task automatic cdb(input int t, input int v);
        idle();
        bus.alu_cdb_valid = 1'b1;
        bus.alu_cdb_entry = 4'(t);
        bus.alu_cdb_val = 32'(v);
    endtask

    task automatic apply(input vec_t r, input int n);
        bus.inst_valid = r.iv[0];
        bus.inst_type = r.ityp[6:0];
        bus.inst_entry = r.itag[3:0];
        bus.inst_pc = pc_of(r.itag);
        bus.inst_val1 = r.iv1;
        bus.inst_val2 = r.iv2;
        bus.inst_q1_busy = r.q1b[0];
        bus.inst_q1 = r.q1[3:0];
        bus.inst_q2_busy = r.q2b[0];
        bus.inst_q2 = r.q2[3:0];
        bus.alu_cdb_valid = r.av[0];
        bus.alu_cdb_entry = r.ae[3:0];
        bus.alu_cdb_val = r.aval;
        bus.lsb_cdb_valid = r.lv[0];
        bus.lsb_cdb_entry = r.le[3:0];
        bus.lsb_cdb_val = r.lval;
        step();
        chk($sformatf("vec%0d execute", n), 32'(bus.execute), 32'(r.e_exe));
        chk($sformatf("vec%0d rs_full", n), 32'(bus.rs_full), 32'd0);
        if (r.e_exe != 0) begin
            chk($sformatf("vec%0d entry", n), 32'(bus.entry), 32'(r.e_tag));
            chk($sformatf("vec%0d val1", n), bus.val1, 32'(r.e_v1));
            chk($sformatf("vec%0d val2", n), bus.val2, 32'(r.e_v2));
            chk($sformatf("vec%0d type", n), 32'(bus.issue_type), 32'(r.e_typ));
            chk($sformatf("vec%0d nowPC", n), bus.nowPC, pc_of(r.e_tag));
        end
    endtask

    initial begin
        vecs[0]  = '{1, 'h13, 3, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 5, 7, 'h13};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 'h33, 5, 1, 0, 0, 0, 1, 4, 0, 0, 0, 1, 4, 'hAB, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 'hAB, 'h33};
        vecs[5]  = '{1, 'h13, 6, 0, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 'h10, 0, 0, 0, BYP, 6, 'h10, 3, 'h13};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1 - BYP, 6, 'h10, 3, 'h13};
        vecs[9]  = '{1, 'h33, 7, 0, 0, 1, 8, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 'h21, 1, 8, 'h99, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h55, BYP, 7, 'h21, 'h55, 'h33};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1 - BYP, 7, 'h21, 'h55, 'h33};
        vecs[13] = '{1, 'h13, 1, 0, 2, 1, 11, 0, 0, 1, 11, 'h31, 1, 11, 'h41, 0, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h31, 2, 'h13};

        idle();
        bus.rdy_in = 1'b1;
        bus.inst_type = '0;
        bus.inst_entry = '0;
        bus.inst_pc = '0;
        bus.inst_val1 = '0;
        bus.inst_val2 = '0;
        bus.inst_q1 = '0;
        bus.inst_q2 = '0;
        bus.alu_cdb_entry = '0;
        bus.alu_cdb_val = '0;
        bus.lsb_cdb_entry = '0;
        bus.lsb_cdb_val = '0;
        repeat (2) step();
        chk("reset execute", 32'(bus.execute), 32'd0);
        chk("reset rs_full", 32'(bus.rs_full), 32'd0);
        chk("reset entry", 32'(bus.entry), 32'd0);
        chk("reset val1", bus.val1, 32'd0);
        chk("reset nowPC", bus.nowPC, 32'd0);
        rst_in = 1'b0;

        for (int i = 0; i < 15; i++) apply(vecs[i], i);

        // stall: dispatch/CDB dropped, state frozen, execute held
        disp(12, 'h77, 1, 1'b0, 0);
        step();
        chk("stall disp execute", 32'(bus.execute), 32'd0);
        disp(13, 'h88, 2, 1'b0, 0);
        bus.rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d execute", i), 32'(bus.execute), 32'd0);
        end
        idle();
        bus.rdy_in = 1'b1;
        step();
        chk("unstall execute", 32'(bus.execute), 32'd1);
        chk("unstall entry", 32'(bus.entry), 32'd12);
        chk("unstall val1", bus.val1, 32'h77);
        bus.rdy_in = 1'b0;
        step();
        chk("stall hold execute", 32'(bus.execute), 32'd1);
        bus.rdy_in = 1'b1;
        step();
        chk("stall drop execute", 32'(bus.execute), 32'd0);

        // fill all entries waiting on tag 9, then wake them together
        for (int i = 0; i < 8; i++) begin
            disp(i, 0, i, 1'b1, 9);
            step();
            chk($sformatf("fill%0d execute", i), 32'(bus.execute), 32'd0);
            chk($sformatf("fill%0d rs_full", i), 32'(bus.rs_full), 32'(i == 7));
        end
        disp(15, 'h99, 1, 1'b0, 0);
        step();
        chk("ninth rs_full", 32'(bus.rs_full), 32'd1);
        chk("ninth execute", 32'(bus.execute), 32'd0);
        cdb(9, 'h42);
        step();
        chk("fill cdb execute", 32'(bus.execute), 32'(BYP));
        idle();
        for (int i = BYP; i < 8; i++) begin
            step();
            chk($sformatf("drain%0d execute", i), 32'(bus.execute), 32'd1);
            chk($sformatf("drain%0d entry", i), 32'(bus.entry), 32'(i));
            chk($sformatf("drain%0d val1", i), bus.val1, 32'h42);
            chk($sformatf("drain%0d val2", i), bus.val2, 32'(i));
            chk($sformatf("drain%0d rs_full", i), 32'(bus.rs_full), 32'd0);
        end
        step();
        chk("drain end execute", 32'(bus.execute), 32'd0);

        // clear with ready entries pending, plus a dispatch the flush must drop
        for (int i = 1; i < 4; i++) begin
            disp(i, i, 0, 1'b1, 10);
            step();
        end
        cdb(10, 5);
        step();
        chk("clear cdb execute", 32'(bus.execute), 32'(BYP));
        disp(4, 4, 4, 1'b0, 0);
        bus.clear = 1'b1;
        step();
        chk("clear execute", 32'(bus.execute), 32'd0);
        chk("clear rs_full", 32'(bus.rs_full), 32'd0);
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post clear%0d execute", i), 32'(bus.execute), 32'd0);
        end

        // asynchronous reset in the middle of an issue stream
        disp(1, 1, 1, 1'b0, 0);
        step();
        disp(2, 2, 2, 1'b0, 0);
        step();
        chk("pre reset execute", 32'(bus.execute), 32'd1);
        chk("pre reset entry", 32'(bus.entry), 32'd1);
        idle();
        #2 rst_in = 1'b1;
        #1;
        chk("async reset execute", 32'(bus.execute), 32'd0);
        chk("async reset rs_full", 32'(bus.rs_full), 32'd0);
        chk("async reset entry", 32'(bus.entry), 32'd0);
        #1 rst_in = 1'b0;
        step();
        chk("post reset execute", 32'(bus.execute), 32'd0);
        step();
        chk("post reset idle execute", 32'(bus.execute), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
